// File: rtl/fpu_issue_ctrl_if.sv
// Request, FPU-drive and writeback signals of the FP issue controller.
// The controller uses the slave view; the decode/FPU/regfile side uses master.
interface fpu_issue_ctrl_if #(
  parameter int RD_W = 5
);
  logic            in_valid;
  logic            out_ready;
  logic [3:0]      in_op;
  logic [1:0]      in_fmt;
  logic            in_addsub_ctrl;
  logic [2:0]      in_ctrl;
  logic [31:0]     in_rs1;
  logic [31:0]     in_rs2;
  logic [RD_W-1:0] in_rd;

  logic [3:0]      out_fpu_op;
  logic [1:0]      out_fpu_fmt;
  logic            out_fpu_addsub;
  logic [2:0]      out_fpu_ctrl;
  logic [31:0]     out_fpu_rs1;
  logic [31:0]     out_fpu_rs2;
  logic            out_fpu_start;
  logic            in_fpu_stall;
  logic [63:0]     in_fpu_data;

  logic            out_wb_valid;
  logic            in_wb_ready;
  logic [63:0]     out_wb_data;
  logic [RD_W-1:0] out_wb_rd;
  logic            out_wb_to_int;
  logic            out_wb_err;

  modport slave (
    input  in_valid, in_op, in_fmt, in_addsub_ctrl, in_ctrl, in_rs1, in_rs2, in_rd,
           in_fpu_stall, in_fpu_data, in_wb_ready,
    output out_ready, out_fpu_op, out_fpu_fmt, out_fpu_addsub, out_fpu_ctrl,
           out_fpu_rs1, out_fpu_rs2, out_fpu_start,
           out_wb_valid, out_wb_data, out_wb_rd, out_wb_to_int, out_wb_err
  );

  modport master (
    output in_valid, in_op, in_fmt, in_addsub_ctrl, in_ctrl, in_rs1, in_rs2, in_rd,
           in_fpu_stall, in_fpu_data, in_wb_ready,
    input  out_ready, out_fpu_op, out_fpu_fmt, out_fpu_addsub, out_fpu_ctrl,
           out_fpu_rs1, out_fpu_rs2, out_fpu_start,
           out_wb_valid, out_wb_data, out_wb_rd, out_wb_to_int, out_wb_err
  );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// FP issue controller: accepts one decoded op, drives the FPU, sequences the
// divider start/stall protocol and holds the result on a writeback port.
module fpu_issue_ctrl #(
  parameter int DIV_TIMEOUT = 64,
  parameter int RD_W        = 5
) (
  input  logic              in_Clk,
  input  logic              in_Rst,
  fpu_issue_ctrl_if.slave   bus
);

  localparam int CNT_W = $clog2(DIV_TIMEOUT + 1);
  localparam logic [3:0] OP_DIV = 4'b0010;

  typedef enum logic [2:0] {IDLE, EXEC, DIV_START, DIV_WAIT, WB} state_e;

  state_e          state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            ready_q;
  logic [3:0]      op_q;
  logic [1:0]      fmt_q;
  logic            addsub_q;
  logic [2:0]      ctrl_q;
  logic [31:0]     rs1_q, rs2_q;
  logic            start_q;
  logic            wb_valid_q;
  logic [63:0]     wb_data_q;
  logic [RD_W-1:0] wb_rd_q;
  logic            wb_to_int_q;
  logic            wb_err_q;

  function automatic logic is_illegal(input logic [3:0] op);
    return (op == 4'b1000) || (op >= 4'b1010);
  endfunction

  function automatic logic is_int_dest(input logic [3:0] op);
    return op inside {4'b0100, 4'b0110, 4'b0111, 4'b1001};
  endfunction

  // Saturating wait counter: holds at DIV_TIMEOUT instead of wrapping.
  // NOTE: combinational blocks use blocking '=' and assign every output up front,
  // so no latch can be inferred; clocked state below uses '<=' only.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != CNT_W'(DIV_TIMEOUT)) cnt_d = cnt_q + 1'b1;
  end

  // NOTE: async reset clears start/valid immediately, so an in-flight op is dropped
  // without a writeback and the divider start pulse cannot outlive the reset.
  always_ff @(posedge in_Clk or posedge in_Rst) begin
    if (in_Rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      op_q        <= '0;
      fmt_q       <= '0;
      addsub_q    <= 1'b0;
      ctrl_q      <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      start_q     <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_data_q   <= '0;
      wb_rd_q     <= '0;
      wb_to_int_q <= 1'b0;
      wb_err_q    <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            op_q        <= bus.in_op;
            fmt_q       <= bus.in_fmt;
            addsub_q    <= bus.in_addsub_ctrl;
            ctrl_q      <= bus.in_ctrl;
            rs1_q       <= bus.in_rs1;
            rs2_q       <= bus.in_rs2;
            wb_rd_q     <= bus.in_rd;
            wb_to_int_q <= is_int_dest(bus.in_op);
            ready_q     <= 1'b0;
            if (bus.in_op == OP_DIV) begin
              start_q <= 1'b1;
              state_q <= DIV_START;
            end else begin
              state_q <= EXEC;
            end
          end
        end
        EXEC: begin
          wb_data_q  <= is_illegal(op_q) ? 64'd0 : bus.in_fpu_data;
          wb_err_q   <= is_illegal(op_q);
          wb_valid_q <= 1'b1;
          state_q    <= WB;
        end
        DIV_START: begin
          cnt_q   <= '0;
          state_q <= DIV_WAIT;
        end
        DIV_WAIT: begin
          // Stall is not trusted in the first wait cycle while the divider latches start.
          if (cnt_q != '0 && !bus.in_fpu_stall) begin
            wb_data_q  <= bus.in_fpu_data;
            wb_err_q   <= 1'b0;
            wb_valid_q <= 1'b1;
            state_q    <= WB;
          end else if (cnt_q == CNT_W'(DIV_TIMEOUT - 1)) begin
            cnt_q      <= cnt_d;
            wb_data_q  <= 64'd0;
            wb_err_q   <= 1'b1;
            wb_valid_q <= 1'b1;
            state_q    <= WB;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        WB: begin
          if (bus.in_wb_ready) begin
            wb_valid_q <= 1'b0;
            ready_q    <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.out_ready      = ready_q;
  assign bus.out_fpu_op     = op_q;
  assign bus.out_fpu_fmt    = fmt_q;
  assign bus.out_fpu_addsub = addsub_q;
  assign bus.out_fpu_ctrl   = ctrl_q;
  assign bus.out_fpu_rs1    = rs1_q;
  assign bus.out_fpu_rs2    = rs2_q;
  assign bus.out_fpu_start  = start_q;
  assign bus.out_wb_valid   = wb_valid_q;
  assign bus.out_wb_data    = wb_data_q;
  assign bus.out_wb_rd      = wb_rd_q;
  assign bus.out_wb_to_int  = wb_to_int_q;
  assign bus.out_wb_err     = wb_err_q;

endmodule
